// File: rtl/mbe_pkg.sv
// mbe_pkg: shared FSM states, digit type and sizing helpers for the radix-8 Booth multiplier.
package mbe_pkg;
  localparam int MANT_W_DEF = 24;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACC, S_DONE} state_t;
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
    logic three;
    logic four;
  } digit_t;
  function automatic int num_dig(input int w);
    return (w + 3) / 3;
  endfunction
  // Sign plus one-hot magnitude; a zero digit leaves every magnitude bit clear.
  function automatic digit_t recode(input logic [3:0] bits);
    logic [2:0] s;
    logic [2:0] m;
    s = {1'b0, bits[2], 1'b0} + {2'b0, bits[1]} + {2'b0, bits[0]};
    m = bits[3] ? 3'd4 - s : s;
    return '{neg: bits[3], one: m == 3'd1, two: m == 3'd2, three: m == 3'd3, four: m == 3'd4};
  endfunction
endpackage

// File: rtl/mbe_digit_sel.sv
// mbe_digit_sel: selects the signed multiple d*A (d in -4..+4) for one radix-8 Booth digit.
module mbe_digit_sel
  import mbe_pkg::*;
#(
  parameter int W = MANT_W_DEF
) (
  input  logic [3:0]          i_bits,
  input  logic [W-1:0]        i_a,
  input  logic [W:0]          i_a2,
  input  logic [W+1:0]        i_a3,
  input  logic [W+1:0]        i_a4,
  output logic signed [W+3:0] o_term
);
  digit_t      w_d;
  logic [W+3:0] w_mag;
  assign w_d   = recode(i_bits);
  assign w_mag = w_d.one   ? {4'b0, i_a}  :
                 w_d.two   ? {3'b0, i_a2} :
                 w_d.three ? {2'b0, i_a3} :
                 w_d.four  ? {2'b0, i_a4} : '0;
  assign o_term = w_d.neg ? -w_mag : w_mag;
endmodule

// File: rtl/mbe_seq_mant_mult.sv
// mbe_seq_mant_mult: sequential radix-8 Booth mantissa multiplier, one digit per cycle.
// Define MBE_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module mbe_seq_mant_mult
  import mbe_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_W-1:0]     a,
  input  logic [MANT_W-1:0]     b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MANT_W-1:0]   prod,
  output logic                  busy
);
  localparam int ND = num_dig(MANT_W);
  localparam int BW = 3 * ND + 1;
  localparam int AW = 2 * MANT_W + 2;
  localparam int TW = MANT_W + 4;
  localparam int IW = ND > 1 ? $clog2(ND) : 1;
  state_t               r_state, w_next;
  logic [MANT_W-1:0]    r_a;
  logic [MANT_W+1:0]    r_a3;
  logic [BW-1:0]        r_bx;
  logic [AW-1:0]        r_acc;
  logic [IW-1:0]        r_idx;
  logic signed [TW-1:0] w_term;
  logic [AW-1:0]        w_add;
  logic [IW+1:0]        w_sh;
  logic                 w_last;
  mbe_digit_sel #(.W(MANT_W)) u_sel (
    .i_bits(r_bx[3:0]),
    .i_a   (r_a),
    .i_a2  ({r_a, 1'b0}),
    .i_a3  (r_a3),
    .i_a4  ({r_a, 2'b00}),
    .o_term(w_term)
  );
  assign w_sh  = {1'b0, r_idx, 1'b0} + {2'b0, r_idx};
  assign w_add = {{(AW - TW){w_term[TW-1]}}, w_term} << w_sh;
  // r_bx shifts right by a digit each cycle, so bits [BW-1:3] are the untouched b bits.
`ifdef MBE_EARLY_TERM_EN
  assign w_last = (r_idx == IW'(ND - 1)) || (r_bx[BW-1:3] == '0);
`else
  assign w_last = r_idx == IW'(ND - 1);
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = in_valid ? S_PRE : S_IDLE;
      S_PRE:   w_next = S_ACC;
      S_ACC:   w_next = w_last ? S_DONE : S_ACC;
      default: w_next = out_ready ? S_IDLE : S_DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_a3    <= '0;
      r_bx    <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && in_valid) begin
        r_a   <= a;
        r_bx  <= BW'({b, 1'b0});
        r_acc <= '0;
        r_idx <= '0;
      end
      if (r_state == S_PRE) r_a3 <= {2'b0, r_a} + {1'b0, r_a, 1'b0};
      if (r_state == S_ACC) begin
        r_acc <= r_acc + w_add;
        r_bx  <= r_bx >> 3;
        r_idx <= r_idx + 1'b1;
      end
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign busy      = r_state == S_PRE || r_state == S_ACC;
  assign prod      = out_valid ? r_acc[2*MANT_W-1:0] : '0;
  a_upper_zero: assert property (@(posedge clk) disable iff (rst)
    r_state == S_DONE |-> r_acc[AW-1:2*MANT_W] == '0);
endmodule

// File: tb/tb_mbe_seq_mant_mult.sv
// tb_mbe_seq_mant_mult: randomized self-checking bench for the sequential Booth multiplier.
module tb_mbe_seq_mant_mult;
  localparam int W  = 24;
  localparam int ND = 9;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] prod;
  int checks = 0, errors = 0;

  mbe_seq_mant_mult #(.MANT_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] y);
`ifdef MBE_EARLY_TERM_EN
    for (int i = 0; i < ND; i++) if ((y >> (3 * i + 2)) == '0) return i + 2;
    return ND + 1;
`else
    return ND + 1;
`endif
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom % 4)
      0:       return '1;
      1:       return W'($urandom % 8);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic rdy,
                       output logic [2*W-1:0] p, output int lat);
    int g = 0;
    @(negedge clk);
    a = x; b = y; in_valid = 1; out_ready = rdy;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    p = prod;
  endtask

  task automatic test_reset();
    rst = 1;
    #12;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || prod !== '0) begin
      errors++;
      $display("FAIL reset: rdy/vld/busy=%b prod=%h, need 100 and 0", {in_ready, out_valid, busy}, prod);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_directed();
    logic [W-1:0] xs[2] = '{24'h800000, 24'hFFFFFF};
    logic [2*W-1:0] ps[2] = '{48'h400000000000, 48'hFFFFFE000001};
    logic [2*W-1:0] p;
    int lat;
    for (int i = 0; i < 2; i++) begin
      do_op(xs[i], xs[i], 1'b1, p, lat);
      checks++;
      if (p !== ps[i]) begin
        errors++;
        $display("FAIL directed_prod[%0d]: got %h need %h", i, p, ps[i]);
      end
      checks++;
      if (lat !== 10) begin
        errors++;
        $display("FAIL directed_lat[%0d]: got %0d need 10", i, lat);
      end
    end
  endtask

  task automatic test_stall();
    logic [2*W-1:0] p;
    int lat;
    do_op(24'h00ABCD, 24'h123457, 1'b0, p, lat);
    checks++;
    if (p !== model(24'h00ABCD, 24'h123457) || lat !== exp_lat(24'h123457)) begin
      errors++;
      $display("FAIL stall_first: prod %h lat %0d need %h lat %0d", p,
               lat, model(24'h00ABCD, 24'h123457), exp_lat(24'h123457));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = rnd(); b = rnd();
      #1;
      checks++;
      if (prod !== p || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: prod %h vld %b rdy %b need %h 1 0", i, prod, out_valid, in_ready, p);
      end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: vld %b rdy %b need 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_no_latch: busy %b rdy %b need 0 1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] p;
    int lat;
    @(negedge clk);
    a = 24'hFFFFFF; b = 24'hFFFFFF; in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: busy %b need 1", busy);
    end
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || prod !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: vld %b busy %b rdy %b prod %h need 0 0 1 0", out_valid, busy, in_ready, prod);
    end
    @(negedge clk);
    rst = 0;
    do_op(24'd3, 24'd5, 1'b1, p, lat);
    checks++;
    if (p !== 48'd15 || lat !== exp_lat(24'd5)) begin
      errors++;
      $display("FAIL midrst_next: prod %h lat %0d need f lat %0d", p, lat, exp_lat(24'd5));
    end
  endtask

`ifdef MBE_EARLY_TERM_EN
  task automatic test_early_term();
    logic [W-1:0] ys[3] = '{24'h000001, 24'h000007, 24'h000000};
    logic [2*W-1:0] ps[3] = '{48'h123456, 48'h7F6E5A, 48'h0};
    int ls[3] = '{2, 3, 2};
    logic [2*W-1:0] p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(24'h123456, ys[i], 1'b1, p, lat);
      checks++;
      if (p !== ps[i] || lat !== ls[i]) begin
        errors++;
        $display("FAIL early[%0d]: prod %h lat %0d need %h lat %0d", i, p, lat, ps[i], ls[i]);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [2*W-1:0] q[$];
    int sent = 0, got = 0, cyc = 0;
    @(negedge clk);
    while (got < 1000 && cyc < 60000) begin
      @(posedge clk);
      #1;
      cyc++;
      in_valid = sent < 1000 && ($urandom % 4 != 0);
      a = rnd(); b = rnd();
      out_ready = $urandom % 3 != 0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model(a, b));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0 || prod !== q[0]) begin
          errors++;
          $display("FAIL b2b_prod[%0d]: got %h need %h", got, prod, q.size() ? q[0] : '0);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
    end
    in_valid = 0;
    checks++;
    if (got !== 1000 || q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d pending %0d need 1000 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
`ifdef MBE_EARLY_TERM_EN
    test_early_term();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mbe_seq_mant_mult.md
# mbe_seq_mant_mult

Sequential radix-8 Modified-Booth mantissa multiplier controller. It accepts two unsigned mantissas and runs one Booth digit per cycle through a single shared digit-select/add slice, accumulating the exact product. It handles handshaking on both sides and sits in the FP multiply path as the area-optimised alternative to the parallel partial-product tree.

## Interface
- `MANT_W`, default 24: mantissa width in bits, unsigned.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in `MANT_W`: multiplicand.
- `b` in `MANT_W`: multiplier (Booth-recoded operand).
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts product.
- `prod` out `2*MANT_W`: exact product `a*b`.
- `busy` out 1: high in PRE or ACC.

## Operation
- `NUM_DIG` = ceil((`MANT_W`+1)/3). This is 9 for `MANT_W`=24.
- Digit i uses bits {b[3i+2], b[3i+1], b[3i], b[3i-1]}.
  - b[-1] = 0.
  - Bits at index ≥ `MANT_W` read as 0.
  - Value: d_i = −4·b[3i+2] + 2·b[3i+1] + b[3i] + b[3i−1], in the range −4..+4.
- FSM states: IDLE, PRE, ACC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `a` and `b`, clear the accumulator, clear the digit index, go to PRE.
- PRE: register 3A = A + 2A. Go to ACC.
- ACC: one digit per cycle.
  - acc += sext(d_i·A) << 3i.
  - Partial term is 28-bit signed; accumulator is 2·`MANT_W`+2 bits, signed.
  - After digit `NUM_DIG`−1, go to DONE.
- DONE:
  - `out_valid`=1; `prod` = acc[2·`MANT_W`−1:0].
  - The upper accumulator bits are guaranteed 0; a non-zero value is an assertion failure.
  - On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. `in_valid` in any other state is ignored; no queuing.
- `prod` and `out_valid` are held stable in DONE until `out_ready`, regardless of `in_valid`.
- Reset or async `rst` mid-operation:
  - Immediate return to IDLE; the operation in flight is discarded.
  - `out_valid`=0, `busy`=0, `in_ready`=1, `prod`=0, accumulator=0, digit index=0.
  - No partial result is ever presented.

## Timing
- Acceptance edge E0 (`in_valid` && `in_ready`).
- E1 completes PRE.
- E2..E10 process digits 0..8.
- `out_valid` is high in the cycle after E10, i.e. 10 cycles of latency, for `MANT_W`=24.
- General latency is `NUM_DIG`+1 cycles.
- Output taken on the edge where `out_valid` && `out_ready`. The block is back in IDLE next cycle, so a new accept is possible one cycle after that.
- Maximum throughput: one product per `NUM_DIG`+3 cycles.
- `out_ready` high on the first DONE cycle leaves DONE after one cycle.

## Configuration
- Macro: `MBE_EARLY_TERM_EN`.
- Defined:
  - After processing digit i in ACC, if b[MANT_W−1:3i+2] == 0, all remaining digits are zero and the FSM goes directly to DONE.
  - Digit 0 is always processed.
  - Latency becomes (index of last processed digit) + 2 cycles. Minimum is 2, for b < 4.
  - Result is identical.
- Undefined: all `NUM_DIG` digits are always processed, giving fixed latency.

## Structure
- Package `mbe_pkg` holds:
  - FSM state enum.
  - `MANT_W_DEF`=24.
  - `NUM_DIG` function/constant.
  - Digit typedef: packed struct {neg, one, two, three, four}, a one-hot magnitude plus sign, 5 bits.
- Sub-module `mbe_digit_sel`:
  - Combinational.
  - Takes 4 recoding bits, A, 2A, 3A, 4A.
  - Returns the signed 28-bit multiple.
  - Zero digit returns 0 regardless of the sign bit.
- The controller owns the FSM, the operand/3A/accumulator registers and the digit index counter.

## Test plan
1. Reset, then a=0x800000, b=0x800000, `out_ready`=1.
   - `prod`=0x400000000000.
   - `out_valid` rises exactly 10 cycles after acceptance (macro off).
2. a=0xFFFFFF, b=0xFFFFFF.
   - `prod`=0xFFFFFE000001.
   - Exercises the −1 digit and the top digit d_8=1.
3. `out_ready` held low 5 cycles in DONE while `in_valid` pulses.
   - `prod`/`out_valid` stable, `in_ready`=0, no new operand latched.
   - Release gives one transfer, then IDLE.
4. Assert `rst` during ACC (3rd digit).
   - Same cycle: `out_valid`=0, `busy`=0, `in_ready`=1.
   - Next operation a=3, b=5 gives `prod`=15.
5. Macro on: a=0x123456.
   - b=0x000001 → `prod`=0x123456 at latency 2.
   - b=0x000007 → `prod`=0x7F6E5A at latency 3 (d_0=−1, d_1=+1).
   - b=0 → `prod`=0 at latency 2.
6. 1000 random back-to-back operands with random `out_ready` stalls, both macro settings.
   - Every `prod` == a·b, no lost or duplicated results.
